sa_autosa_ssa_hs_src: RTL and testbench

Source-side controller for a four-phase request/acknowledge handshake that carries a bundled data word from the source clock domain to a destination domain. It turns single-cycle requests into a held request level and a stable data word. It waits for the acknowledge level, which returns through an external three-flop synchronizer, before it releases the request. It buffers one extra request while a transfer is in flight and flags overflow and protocol errors. The block sits in the source clock domain, next to the destination-side synchronizer pair that completes the crossing.

---
 rtl/sa_autosa_ssa_hs_src.sv | 106 ++++++++++
 tb/tb_sa_autosa_ssa_hs_src.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_autosa_ssa_hs_src.sv
// Source-side four-phase req/ack handshake controller with a one-deep pending slot.
// It holds req_lvl and data_o stable until the synchronized acknowledge completes the handshake.
module sa_autosa_ssa_hs_src #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          req_pulse,
  input  logic [DW-1:0] req_data,
  input  logic          ack_sync,
  input  logic          ovf_clr,
  output logic          req_lvl,
  output logic [DW-1:0] data_o,
  output logic          busy,
  output logic          done_pulse,
  output logic          ovf,
  output logic          proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t        state, state_n;
  logic          pend_v, pend_v_n;
  logic [DW-1:0] pend_d, pend_d_n;
  logic [DW-1:0] data_n;
  logic          handshake_end;
  logic          launch_pend, launch_new;
  logic          store, drop;
  logic          ovf_n, proto_err_n;

  // NOTE: every signal is given a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n       = state;
    pend_v_n      = pend_v;
    pend_d_n      = pend_d;
    data_n        = data_o;
    launch_pend   = 1'b0;
    launch_new    = 1'b0;
    handshake_end = (state == REL) && !ack_sync;

    case (state)
      IDLE: if (req_pulse) begin
        launch_new = 1'b1;
        state_n    = REQ;
      end
      REQ: if (ack_sync) state_n = REL;
      REL: if (!ack_sync) begin
        if (pend_v) begin
          launch_pend = 1'b1;
          state_n     = REQ;
        end else if (req_pulse) begin
          launch_new = 1'b1;
          state_n    = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch_pend) begin
      data_n   = pend_d;
      pend_v_n = 1'b0;
    end
    if (launch_new) data_n = req_data;

    // A request not consumed directly goes to the slot if it is empty or being freed this cycle.
    store = req_pulse && !launch_new && (!pend_v || launch_pend);
    drop  = req_pulse && !launch_new && pend_v && !launch_pend;
    if (store) begin
      pend_v_n = 1'b1;
      pend_d_n = req_data;
    end

    // Set beats clear for the sticky flags.
    ovf_n       = drop || (ovf && !ovf_clr);
    proto_err_n = ((state == IDLE) && ack_sync) || (proto_err && !ovf_clr);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  // NOTE: pend_d and data_o are reset too, so nothing stale is visible on data_o after a reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      pend_v     <= 1'b0;
      pend_d     <= '0;
      data_o     <= '0;
      req_lvl    <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      ovf        <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_n;
      pend_v     <= pend_v_n;
      pend_d     <= pend_d_n;
      data_o     <= data_n;
      req_lvl    <= (state_n == REQ);
      busy       <= (state_n != IDLE) || pend_v_n;
      done_pulse <= handshake_end;
      ovf        <= ovf_n;
      proto_err  <= proto_err_n;
    end
  end

endmodule

// File: tb/tb_sa_autosa_ssa_hs_src.sv
// Scoreboard bench for sa_autosa_ssa_hs_src: a transaction-level model predicts every output cycle,
// a monitor on the falling edge pops and compares; directed scenarios, a random phase and an async reset.
module tb_sa_autosa_ssa_hs_src;

  typedef struct packed {
    logic        req_lvl;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        perr;
    logic [31:0] data;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        req_pulse = 1'b0;
  logic [31:0] req_data = '0;
  logic        ack_sync = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        req_lvl;
  logic [31:0] data_o;
  logic        busy;
  logic        done_pulse;
  logic        ovf;
  logic        proto_err;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  // Reference model: one transfer in flight (request or release half) plus a waiting list.
  bit          m_flight, m_rel, m_ovf, m_perr;
  logic [31:0] m_data;
  logic [31:0] m_pend[$];

  sa_autosa_ssa_hs_src #(.DW(32)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .req_pulse(req_pulse), .req_data(req_data),
    .ack_sync(ack_sync), .ovf_clr(ovf_clr), .req_lvl(req_lvl), .data_o(data_o),
    .busy(busy), .done_pulse(done_pulse), .ovf(ovf), .proto_err(proto_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  task automatic model_reset();
    m_flight = 0; m_rel = 0; m_ovf = 0; m_perr = 0; m_data = '0;
    m_pend.delete();
  endtask

  // Predicts the outputs after the coming edge for the given inputs and queues them.
  task automatic model_step(input bit rp, input logic [31:0] rd, input bit ack, input bit clr);
    bit   consumed = 0, freed = 0, drop = 0, perr_set = 0, done = 0;
    int   pend_was = m_pend.size();
    exp_t e;
    if (!m_flight) begin
      if (ack) perr_set = 1;
      if (rp) begin m_data = rd; m_flight = 1; m_rel = 0; consumed = 1; end
    end else if (!m_rel) begin
      if (ack) m_rel = 1;
    end else if (!ack) begin
      done = 1;
      if (pend_was > 0) begin
        m_data = m_pend.pop_front(); m_rel = 0; freed = 1;
      end else if (rp) begin
        m_data = rd; m_rel = 0; consumed = 1;
      end else begin
        m_flight = 0;
      end
    end
    if (rp && !consumed) begin
      if (pend_was == 0 || freed) m_pend.push_back(rd);
      else drop = 1;
    end
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    if (perr_set) m_perr = 1; else if (clr) m_perr = 0;
    e.req_lvl = m_flight && !m_rel;
    e.busy    = m_flight || (m_pend.size() > 0);
    e.done    = done;
    e.ovf     = m_ovf;
    e.perr    = m_perr;
    e.data    = m_data;
    exp_q.push_back(e);
  endtask

  task automatic step_now(input bit rp, input logic [31:0] rd, input bit ack, input bit clr);
    req_pulse = rp; req_data = rd; ack_sync = ack; ovf_clr = clr;
    model_step(rp, rd, ack, clr);
  endtask

  task automatic drive(input bit rp, input logic [31:0] rd, input bit ack, input bit clr);
    @(posedge i_clk);
    #1;
    step_now(rp, rd, ack, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
  endtask

  task automatic acked(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 1, 0);
  endtask

  task automatic release_reset();
    @(posedge i_clk);
    #2;
    i_rstn = 1'b1;
    model_reset();
    exp_q.push_back(idle_exp());
    step_now(0, '0, 0, 0);
    mon_en = 1'b1;
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("req_lvl", {31'd0, req_lvl}, {31'd0, e.req_lvl});
        check("busy", {31'd0, busy}, {31'd0, e.busy});
        check("done_pulse", {31'd0, done_pulse}, {31'd0, e.done});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("proto_err", {31'd0, proto_err}, {31'd0, e.perr});
        check("data_o", data_o, e.data);
      end
    end
  end

  initial begin
    int          dly;
    bit          a;
    model_reset();
    repeat (3) @(posedge i_clk);
    release_reset();

    // Single transfer.
    drive(1, 32'hA5A5_0001, 0, 0); idle(6); acked(8); idle(3);
    // Pending launch: second request queued while the first is in REQ.
    drive(1, 32'h1, 0, 0); idle(2); drive(1, 32'h2, 0, 0); idle(3); acked(8);
    drive(0, '0, 0, 0); acked(3); idle(3);
    // Overflow: third request dropped, then cleared.
    drive(1, 32'h1, 0, 0); idle(1); drive(1, 32'h2, 0, 0); idle(1); drive(1, 32'h3, 0, 0);
    idle(3); acked(3); drive(0, '0, 0, 0); acked(3); idle(3);
    drive(0, '0, 0, 1); idle(2);
    // Completion and fresh request in the same cycle.
    drive(1, 32'h6, 0, 0); idle(1); acked(2); drive(1, 32'h7, 0, 0); acked(2); idle(2);
    // Overwrite of a slot being freed while it launches.
    drive(1, 32'h10, 0, 0); drive(1, 32'h11, 0, 0); acked(2); drive(1, 32'h12, 0, 0);
    acked(2); drive(0, '0, 0, 0); acked(2); idle(3);
    // Protocol error in IDLE, clear colliding with a new error, then a normal transfer.
    drive(0, '0, 1, 0); idle(2); drive(0, '0, 1, 1); drive(0, '0, 0, 1); idle(2);
    drive(1, 32'hBEEF, 0, 0); idle(1); acked(2); idle(3);

    // Random traffic against a randomly delayed destination responder.
    dly = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge i_clk);
      #1;
      a = ack_sync;
      if (ack_sync != req_lvl) begin
        if (dly == 0) begin
          a = req_lvl;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
      if (i < 1450)
        step_now($urandom_range(0, 9) < 3, $urandom, a, $urandom_range(0, 49) == 0);
      else
        step_now(0, '0, a, 0);
    end

    // Asynchronous reset while in REQ with a pending entry.
    drive(0, '0, 0, 1); idle(1);
    drive(1, 32'h9, 0, 0); drive(1, 32'hA, 0, 0);
    @(posedge i_clk);
    #3;
    mon_en = 1'b0;
    exp_q.delete();
    req_pulse = 0; req_data = '0; ack_sync = 0; ovf_clr = 0;
    check("pre_reset_req_lvl", {31'd0, req_lvl}, 32'd1);
    i_rstn = 1'b0;
    #1;
    check("rst_req_lvl", {31'd0, req_lvl}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
    repeat (2) @(posedge i_clk);
    release_reset();
    idle(5);
    drive(1, 32'h55, 0, 0); idle(1); acked(2); idle(3);

    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
